// File: rtl/small_filter_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed state-variable filter.
package small_filter_pkg;

    typedef enum logic [1:0] {
        MODE_LP = 2'd0,
        MODE_HP = 2'd1,
        MODE_BP = 2'd2,
        MODE_BS = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_K0_SHIFT = 6;
    localparam int DEF_K1_SHIFT = 6;
    localparam int DEF_BP_ACC_W = DEF_WIDTH + DEF_K0_SHIFT;
    localparam int DEF_LP_ACC_W = DEF_WIDTH + DEF_K1_SHIFT;

    // All datapath math is done in 32-bit signed and then fitted to w bits.
    function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

    function automatic logic signed [31:0] wrap(input logic signed [31:0] v, input int w);
        logic signed [31:0] t;
        t = v <<< (32 - w);
        return t >>> (32 - w);
    endfunction

    function automatic logic signed [31:0] fit(input logic signed [31:0] v, input int w,
                                               input bit clamp);
        return clamp ? sat(v, w) : wrap(v, w);
    endfunction

endpackage

// File: rtl/small_filter_rr_arb.sv
// Round-robin arbiter: search starts one past the last granted channel.
module small_filter_rr_arb #(
    parameter int NUM_CH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         req_i,
    input  logic                      advance_i,
    output logic [NUM_CH-1:0]         grant_o,
    output logic [$clog2(NUM_CH)-1:0] grant_idx_o
);
    localparam int IDX_W = $clog2(NUM_CH);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] idx;
    logic             found;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = ptr_q + IDX_W'(i);
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance_i && found) begin
            ptr_q <= grant_idx_o + IDX_W'(1);
        end
    end

endmodule

// File: rtl/small_filter_tdm_scheduler.sv
// One state-variable filter datapath shared across NUM_CH channels with a
// per-channel accumulator register file and an IDLE/CALC/OUT sequencer.
module small_filter_tdm_scheduler
    import small_filter_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int K0_SHIFT = DEF_K0_SHIFT,
    parameter int K1_SHIFT = DEF_K1_SHIFT,
    parameter int CLAMP    = 1
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic [NUM_CH-1:0]         inValid,
    input  logic [NUM_CH*WIDTH-1:0]   inData,
    output logic [NUM_CH-1:0]         inReady,
    input  logic [NUM_CH-1:0]         clrCh,
    input  logic                      cfgWe,
    input  logic [$clog2(NUM_CH)-1:0] cfgCh,
    input  logic [1:0]                cfgMode,
    output logic                      outValid,
    input  logic                      outReady,
    output logic [WIDTH-1:0]          outData,
    output logic [$clog2(NUM_CH)-1:0] outCh
);
    localparam int IDX_W    = $clog2(NUM_CH);
    localparam int BPW      = WIDTH + K0_SHIFT;
    localparam int LPW      = WIDTH + K1_SHIFT;
    localparam bit CLAMP_EN = (CLAMP != 0);

    state_e                   state_q;
    logic signed [WIDTH-1:0]  x_q;
    logic [IDX_W-1:0]         ch_q;
    mode_e                    mode_cur_q;
    logic                     out_valid_q;
    logic [WIDTH-1:0]         out_data_q;
    logic [IDX_W-1:0]         out_ch_q;

    logic signed [BPW-1:0]    bp_acc_q [NUM_CH];
    logic signed [LPW-1:0]    lp_acc_q [NUM_CH];
    mode_e                    mode_q   [NUM_CH];

    logic [NUM_CH-1:0]        grant;
    logic [IDX_W-1:0]         grant_idx;

    small_filter_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .clk         (clk),
        .rst_n       (rstN),
        .req_i       (inValid),
        .advance_i   (state_q == ST_IDLE),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // Grants only in IDLE; gated by reset so inReady is low while rstN is asserted.
    assign inReady  = (state_q == ST_IDLE && rstN) ? grant : '0;
    assign outValid = out_valid_q;
    assign outData  = out_data_q;
    assign outCh    = out_ch_q;

    logic signed [31:0] x_s, bpa, lpa, bp, lp, hp, bpa_n, lpa_n, bp_o, lp_o, bs, res;

    always_comb begin
        x_s   = 32'(x_q);
        bpa   = 32'(bp_acc_q[ch_q]);
        lpa   = 32'(lp_acc_q[ch_q]);
        bp    = bpa >>> K0_SHIFT;
        lp    = lpa >>> K1_SHIFT;
        hp    = fit(x_s - lp - bp, WIDTH, CLAMP_EN);
        bpa_n = fit(bpa + hp, BPW, CLAMP_EN);
        lpa_n = fit(lpa + (bpa_n >>> K0_SHIFT), LPW, CLAMP_EN);
        bp_o  = bpa_n >>> K0_SHIFT;
        lp_o  = lpa_n >>> K1_SHIFT;
        bs    = sat(x_s - bp_o, WIDTH);
        unique case (mode_cur_q)
            MODE_LP: res = lp_o;
            MODE_HP: res = hp;
            MODE_BP: res = bp_o;
            default: res = bs;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            ch_q        <= '0;
            mode_cur_q  <= MODE_LP;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: if (|inValid) begin
                    x_q        <= inData[grant_idx*WIDTH +: WIDTH];
                    ch_q       <= grant_idx;
                    // A mode write landing on the grant edge applies to this sample.
                    mode_cur_q <= (cfgWe && cfgCh == grant_idx) ? mode_e'(cfgMode)
                                                                : mode_q[grant_idx];
                    state_q    <= ST_CALC;
                end
                ST_CALC: begin
                    out_data_q  <= WIDTH'(res);
                    out_ch_q    <= ch_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: if (outReady) begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the register file is reset explicitly because zero state is architectural.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int c = 0; c < NUM_CH; c++) begin
                bp_acc_q[c] <= '0;
                lp_acc_q[c] <= '0;
                mode_q[c]   <= MODE_LP;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (clrCh[c]) begin
                    bp_acc_q[c] <= '0;
                    lp_acc_q[c] <= '0;
                end else if (state_q == ST_CALC && ch_q == IDX_W'(c)) begin
                    bp_acc_q[c] <= BPW'(bpa_n);
                    lp_acc_q[c] <= LPW'(lpa_n);
                end
            end
            if (cfgWe) mode_q[cfgCh] <= mode_e'(cfgMode);
        end
    end

endmodule
